// File: rtl/conv_window_addr_gen.sv
// Read-address sequencer for convolution/pooling windows (HWC layout).
// Walks output pixels, kernel rows/cols and channels, one beat per valid/ready transfer.
module conv_window_addr_gen #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned SIDE_W = 8,
    parameter int unsigned CH_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [SIDE_W-1:0] kernel,
    input  logic [SIDE_W-1:0] stride,
    input  logic [SIDE_W-1:0] pad,
    input  logic [SIDE_W-1:0] i_side,
    input  logic [SIDE_W-1:0] o_side,
    input  logic [CH_W-1:0]   i_channel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pad,
    output logic              rd_last_win,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);
    localparam int unsigned EXT_W = SIDE_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [SIDE_W-1:0] r_k, r_s, r_p, r_w, r_o;
    logic [CH_W-1:0]   r_ch;

    logic [SIDE_W-1:0] r_oy, r_ox, r_ky, r_kx;
    logic [CH_W-1:0]   r_c;

    logic [ADDR_W-1:0] r_addr;
    logic              r_pad, r_last, r_valid, r_busy, r_done;

    logic [SIDE_W-1:0] w_adv_oy, w_adv_ox, w_adv_ky, w_adv_kx;
    logic [CH_W-1:0]   w_adv_c;
    logic              w_c_end, w_kx_end, w_ky_end, w_ox_end, w_oy_end, w_final;

    logic              w_idle, w_zero_cfg, w_cfg_load;
    logic [SIDE_W-1:0] w_b_oy, w_b_ox, w_b_ky, w_b_kx;
    logic [CH_W-1:0]   w_b_c;
    logic [ADDR_W-1:0] w_base;
    logic [SIDE_W-1:0] w_k, w_s, w_p, w_w;
    logic [CH_W-1:0]   w_ch;

    logic [EXT_W-1:0]  w_iy, w_ix;
    logic [ADDR_W-1:0] w_lin, w_beat_addr;
    logic              w_beat_pad, w_beat_last;

    logic [SIDE_W-1:0] w_oy_nxt, w_ox_nxt, w_ky_nxt, w_kx_nxt;
    logic [CH_W-1:0]   w_c_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_pad_nxt, w_last_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;

    assign w_c_end  = (r_c  == r_ch - CH_W'(1));
    assign w_kx_end = (r_kx == r_k - SIDE_W'(1));
    assign w_ky_end = (r_ky == r_k - SIDE_W'(1));
    assign w_ox_end = (r_ox == r_o - SIDE_W'(1));
    assign w_oy_end = (r_oy == r_o - SIDE_W'(1));
    assign w_final  = w_c_end & w_kx_end & w_ky_end & w_ox_end & w_oy_end;

    // Odometer increment: channel innermost, then kx, ky, ox, oy.
    always_comb begin
        w_adv_oy = r_oy;
        w_adv_ox = r_ox;
        w_adv_ky = r_ky;
        w_adv_kx = r_kx;
        w_adv_c  = r_c;
        if (!w_c_end) begin
            w_adv_c = r_c + CH_W'(1);
        end else begin
            w_adv_c = '0;
            if (!w_kx_end) begin
                w_adv_kx = r_kx + SIDE_W'(1);
            end else begin
                w_adv_kx = '0;
                if (!w_ky_end) begin
                    w_adv_ky = r_ky + SIDE_W'(1);
                end else begin
                    w_adv_ky = '0;
                    if (!w_ox_end) begin
                        w_adv_ox = r_ox + SIDE_W'(1);
                    end else begin
                        w_adv_ox = '0;
                        w_adv_oy = r_oy + SIDE_W'(1);
                    end
                end
            end
        end
    end

    // The first beat is computed from the live config inputs, later beats from the latched copy.
    assign w_idle     = (r_state == IDLE);
    assign w_zero_cfg = (kernel == '0) | (i_channel == '0) | (o_side == '0);
    assign w_cfg_load = w_idle & start;

    assign w_b_oy = w_idle ? '0 : w_adv_oy;
    assign w_b_ox = w_idle ? '0 : w_adv_ox;
    assign w_b_ky = w_idle ? '0 : w_adv_ky;
    assign w_b_kx = w_idle ? '0 : w_adv_kx;
    assign w_b_c  = w_idle ? '0 : w_adv_c;

    assign w_base = w_idle ? base_addr : r_base;
    assign w_k    = w_idle ? kernel    : r_k;
    assign w_s    = w_idle ? stride    : r_s;
    assign w_p    = w_idle ? pad       : r_p;
    assign w_w    = w_idle ? i_side    : r_w;
    assign w_ch   = w_idle ? i_channel : r_ch;

    assign w_iy = EXT_W'(w_b_oy) * EXT_W'(w_s) + EXT_W'(w_b_ky) - EXT_W'(w_p);
    assign w_ix = EXT_W'(w_b_ox) * EXT_W'(w_s) + EXT_W'(w_b_kx) - EXT_W'(w_p);

    assign w_beat_pad = w_iy[EXT_W-1] | w_ix[EXT_W-1]
                      | ($signed(w_iy) >= $signed(EXT_W'(w_w)))
                      | ($signed(w_ix) >= $signed(EXT_W'(w_w)));

    assign w_lin       = ADDR_W'(w_iy) * ADDR_W'(w_w) + ADDR_W'(w_ix);
    assign w_beat_addr = w_beat_pad ? '0 : (w_base + w_lin * ADDR_W'(w_ch) + ADDR_W'(w_b_c));
    assign w_beat_last = (w_b_ky == w_k - SIDE_W'(1)) & (w_b_kx == w_k - SIDE_W'(1))
                       & (w_b_c == w_ch - CH_W'(1));

    // Next state, next counters and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_oy_nxt    = r_oy;
        w_ox_nxt    = r_ox;
        w_ky_nxt    = r_ky;
        w_kx_nxt    = r_kx;
        w_c_nxt     = r_c;
        w_addr_nxt  = r_addr;
        w_pad_nxt   = r_pad;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (w_zero_cfg) begin
                        w_state_nxt = FLUSH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_valid_nxt = 1'b1;
                        w_oy_nxt    = w_b_oy;
                        w_ox_nxt    = w_b_ox;
                        w_ky_nxt    = w_b_ky;
                        w_kx_nxt    = w_b_kx;
                        w_c_nxt     = w_b_c;
                        w_addr_nxt  = w_beat_addr;
                        w_pad_nxt   = w_beat_pad;
                        w_last_nxt  = w_beat_last;
                    end
                end
            end
            RUN: begin
                if (rd_ready) begin
                    if (w_final) begin
                        w_state_nxt = FLUSH;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_addr_nxt  = '0;
                        w_pad_nxt   = 1'b0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_oy_nxt   = w_b_oy;
                        w_ox_nxt   = w_b_ox;
                        w_ky_nxt   = w_b_ky;
                        w_kx_nxt   = w_b_kx;
                        w_c_nxt    = w_b_c;
                        w_addr_nxt = w_beat_addr;
                        w_pad_nxt  = w_beat_pad;
                        w_last_nxt = w_beat_last;
                    end
                end
            end
            FLUSH: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_k     <= '0;
            r_s     <= '0;
            r_p     <= '0;
            r_w     <= '0;
            r_o     <= '0;
            r_ch    <= '0;
            r_oy    <= '0;
            r_ox    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_c     <= '0;
            r_addr  <= '0;
            r_pad   <= 1'b0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_load) begin
                r_base <= base_addr;
                r_k    <= kernel;
                r_s    <= stride;
                r_p    <= pad;
                r_w    <= i_side;
                r_o    <= o_side;
                r_ch   <= i_channel;
            end
            r_oy    <= w_oy_nxt;
            r_ox    <= w_ox_nxt;
            r_ky    <= w_ky_nxt;
            r_kx    <= w_kx_nxt;
            r_c     <= w_c_nxt;
            r_addr  <= w_addr_nxt;
            r_pad   <= w_pad_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign rd_addr     = r_addr;
    assign rd_pad      = r_pad;
    assign rd_last_win = r_last;
    assign rd_valid    = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/conv_window_addr_gen.md
Name: conv_window_addr_gen

Overview:
- Parametrised read-address sequencer between the engine and the DMA read port (p2, data path).
- Walks every convolution/pooling window for a layer: output pixel (row-major), then kernel row, kernel column, then input channel (channel innermost, HWC layout).
- Issues one feature-map address per beat over a valid/ready handshake.
- Generalises the fixed 3x3/stride-2/3-channel fetch order with configurable kernel, stride, side, channel count and zero padding; padded positions are flagged rather than fetched.

Parameters:
- ADDR_W, 24, width of DMA word address.
- SIDE_W, 8, width of i_side/o_side/kernel/stride/pad fields.
- CH_W, 16, width of i_channel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  one-cycle request; config is latched when start=1 and busy=0.
- base_addr  in  ADDR_W  feature-map base word address.
- kernel  in  SIDE_W  kernel side K (>=1).
- stride  in  SIDE_W  stride S (>=1).
- pad  in  SIDE_W  zero-pad P (< K).
- i_side  in  SIDE_W  input side W.
- o_side  in  SIDE_W  output side O.
- i_channel  in  CH_W  channel count C (>=1).
- rd_addr  out  ADDR_W  word address for the current beat.
- rd_pad  out  1  beat is a padding position; consumer substitutes 16'h0000 and does not fetch.
- rd_last_win  out  1  last beat of the current window.
- rd_valid  out  1  beat valid.
- rd_ready  in  1  DMA/consumer accepts the beat.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE and all counters clear.
  - This applies mid-sequence too: no further beats are issued.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - On start, latch all config and clear counters oy, ox, ky, kx, c.
  - busy=1 next cycle; go to RUN.
  - First rd_valid is asserted 1 cycle after start is sampled.
- RUN:
  - rd_valid=1 every cycle.
  - A beat transfers when rd_valid && rd_ready. On transfer, c increments; on wrap it carries into kx, then ky, then ox, then oy.
  - While rd_ready=0: rd_addr, rd_pad and rd_last_win hold stable and counters hold.
- Per-beat arithmetic:
  - iy = oy*S + ky − P and ix = ox*S + kx − P, computed signed with SIDE_W+2 bits.
  - rd_pad = (iy<0) | (ix<0) | (iy>=W) | (ix>=W).
  - When rd_pad=0: rd_addr = base_addr + ((iy*W + ix)*C + c), truncated modulo 2^ADDR_W.
  - When rd_pad=1: rd_addr = 0.
- rd_last_win = (ky==K−1) & (kx==K−1) & (c==C−1).
- Beats per window = K*K*C. Total beats = O*O*K*K*C.
- Final beat (oy=ox=O−1, ky=kx=K−1, c=C−1) accepted → go to FLUSH.
- FLUSH:
  - rd_valid=0 and done=1 for exactly one cycle.
  - Next cycle: busy=0, back to IDLE.
- start while busy=1 is ignored; config inputs may change freely while busy.
- start on the same cycle as the done pulse is ignored. start is accepted in IDLE only.
- Degenerate cases:
  - K=1, C=1, O=1 → exactly one beat; rd_last_win=1 on that beat.
  - Zero config fields (K, C or O = 0) → no beats; done pulses 1 cycle after start; busy is high for that single cycle.
- Outputs are registered. Address arithmetic may be pipelined internally, but a transfer every cycle must be sustainable when rd_ready is held at 1.

Test Plan:
- Unpadded stride-2 layer: base=0, W=5, K=3, S=2, P=0, C=3, O=2, rd_ready=1.
  - Exactly 108 beats with rd_pad=0.
  - First 9 addresses 0..8; beat 9 → address 15.
  - Window 2 (ox=1) starts at address 6; window 3 (oy=1) starts at address 30.
  - rd_last_win on beats 26, 53, 80, 107; done pulses the cycle after beat 107.
- Padded layer: W=3, K=3, S=1, P=1, C=1, O=3.
  - First window rd_pad sequence 1,1,1,1,0,0,1,0,0.
  - Non-pad addresses in that window: 0,1,3,4.
  - Centre window (beats 36..44) has all rd_pad=0 with addresses 0..8.
- Backpressure: same config as the first scenario; drive rd_ready low on random cycles.
  - rd_addr, rd_pad and rd_last_win stay stable while stalled.
  - Beat sequence is identical to the first scenario; total stays 108.
- Reset mid-sequence: pull rst low at beat 40 for one cycle.
  - Next cycle rd_valid=0, busy=0, no done pulse.
  - A new start restarts from address base+0.
- Start while busy and degenerate configs:
  - A second start pulse mid-run is ignored (still 108 beats, one done).
  - K=1, C=1, O=1, base=24'h000100 → single beat, address 24'h000100, rd_last_win=1, then done.
  - C=0 → no beats; done one cycle after start.
- Address wrap: base=24'hFFFFFE, W=2, K=1, S=1, P=0, C=1, O=2 → addresses FFFFFE, FFFFFF, 000000, 000001.
